// File: rtl/param_stream_sink_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : param_stream_pkg                                             |
// | Purpose : Shared types and constants for the parameter-stream sink.    |
// |           Holds the sink FSM state type, the default element width,    |
// |           the checksum width and the read-port latency.                |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package param_stream_pkg;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_DONE = 1'b1
  } state_e;

  localparam int DEFAULT_PRECISION = 16;
  localparam int CHECKSUM_WIDTH    = 32;
  localparam int READ_LATENCY      = 2;

endpackage
`default_nettype wire

// File: rtl/param_stream_sink_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : param_stream_sink_if                                       |
// | Purpose   : Bundles the beat handshake, load control, read port and    |
// |             checksum of the parameter-stream sink.                     |
// | Signals   : data_in[P]     beat elements (element j = lower index)     |
// |             data_in_valid  beat valid                                  |
// |             data_in_ready  sink ready                                  |
// |             start          one-cycle re-arm pulse                      |
// |             done           full load captured                          |
// |             rd_addr        read word address                           |
// |             rd_ce          read pipeline enable                        |
// |             rd_data        read word (2 rd_ce edges after address)     |
// |             checksum       running element sum                         |
// | Modports  : master (stream source / reader), slave (the sink)          |
// | Rev       : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface param_stream_sink_if
  import param_stream_pkg::*;
#(
  parameter int PRECISION_0       = DEFAULT_PRECISION,
  parameter int TENSOR_SIZE_DIM_0 = 32,
  parameter int PARALLELISM_DIM_0 = 4,
  parameter int PARALLELISM_DIM_1 = 1,
  parameter int MEM_DEPTH         = 8
);

  localparam int P      = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int AWIDTH = $clog2(MEM_DEPTH) + 1;

  logic [PRECISION_0-1:0]                   data_in [P];
  logic                                     data_in_valid;
  logic                                     data_in_ready;
  logic                                     start;
  logic                                     done;
  logic [AWIDTH-1:0]                        rd_addr;
  logic                                     rd_ce;
  logic [PRECISION_0*TENSOR_SIZE_DIM_0-1:0] rd_data;
  logic [CHECKSUM_WIDTH-1:0]                checksum;

  modport master (
    output data_in, data_in_valid, start, rd_addr, rd_ce,
    input  data_in_ready, done, rd_data, checksum
  );

  modport slave (
    input  data_in, data_in_valid, start, rd_addr, rd_ce,
    output data_in_ready, done, rd_data, checksum
  );

endinterface
`default_nettype wire

// File: rtl/param_stream_sink_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : param_stream_sink_ram                                        |
// | Purpose : Simple dual-port RAM, one write port and a two-stage read    |
// |           pipeline gated by a clock enable. Read-first: a read and a   |
// |           write to the same word on one edge return the old contents.  |
// |           Addresses at or beyond DEPTH read back as zero.              |
// | Ports   : clk, rst (sync, active-high; clears read pipeline only)      |
// |           we_i, waddr_i, wdata_i          write port                   |
// |           rd_addr_i, rd_ce_i, rd_data_o   read port                    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module param_stream_sink_ram #(
  parameter int DWIDTH = 512,
  parameter int DEPTH  = 8,
  parameter int AWIDTH = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              we_i,
  input  wire logic [AWIDTH-1:0] waddr_i,
  input  wire logic [DWIDTH-1:0] wdata_i,
  input  wire logic [AWIDTH-1:0] rd_addr_i,
  input  wire logic              rd_ce_i,
  output logic      [DWIDTH-1:0] rd_data_o
);

  localparam int                IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH-1:0] DEPTH_A = AWIDTH'(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] stage1_q;
  logic [DWIDTH-1:0] stage2_q;
  logic              rd_in_range;
  logic              wr_in_range;

  assign rd_in_range = (rd_addr_i < DEPTH_A);
  assign wr_in_range = (waddr_i < DEPTH_A);

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i && wr_in_range) begin
      mem_q[waddr_i[IDXW-1:0]] <= wdata_i;
    end
  end

  // Non-blocking update of mem_q gives read-first behaviour for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else if (rd_ce_i) begin
      stage1_q <= rd_in_range ? mem_q[rd_addr_i[IDXW-1:0]] : '0;
      stage2_q <= stage1_q;
    end
  end

  assign rd_data_o = stage2_q;

endmodule
`default_nettype wire

// File: rtl/param_stream_sink.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : param_stream_sink                                            |
// | Purpose : Receiving end of the parameter-stream protocol. Packs beats  |
// |           of P elements into tensor-row words, writes MEM_DEPTH words  |
// |           into an internal RAM, then raises done until start re-arms.  |
// |           The RAM is readable at any time with 2-cycle ROM timing.     |
// | Ports   : clk, rst (sync, active-high)                                 |
// |           bus (param_stream_sink_if.slave): beat handshake, start/done,|
// |           read port and checksum                                       |
// | Macro   : PARAM_STREAM_SINK_CHECKSUM_EN - when defined, checksum is    |
// |           the mod-2^32 sum of all accepted elements; otherwise 0.      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module param_stream_sink
  import param_stream_pkg::*;
#(
  parameter int PRECISION_0       = DEFAULT_PRECISION,
  parameter int TENSOR_SIZE_DIM_0 = 32,
  parameter int PARALLELISM_DIM_0 = 4,
  parameter int PARALLELISM_DIM_1 = 1,
  parameter int MEM_DEPTH         = 8
) (
  input wire logic            clk,
  input wire logic            rst,
  param_stream_sink_if.slave  bus
);

  localparam int P              = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int BEATS_PER_WORD = TENSOR_SIZE_DIM_0 / P;
  localparam int AWIDTH         = $clog2(MEM_DEPTH) + 1;
  localparam int BCW            = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
  localparam int BEAT_W         = PRECISION_0 * P;
  localparam int WORD_W         = PRECISION_0 * TENSOR_SIZE_DIM_0;

  localparam logic [0:0]        ST_LOAD   = S_LOAD;
  localparam logic [0:0]        ST_DONE   = S_DONE;
  localparam logic [BCW-1:0]    LAST_BEAT = BCW'(BEATS_PER_WORD - 1);
  localparam logic [AWIDTH-1:0] LAST_WORD = AWIDTH'(MEM_DEPTH - 1);

  if ((TENSOR_SIZE_DIM_0 % P) != 0) begin : g_bad_cfg
    $error("param_stream_sink: TENSOR_SIZE_DIM_0 must be a multiple of P");
  end

  logic [0:0]        state_q,    state_d;
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [AWIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [BEAT_W-1:0] beat_flat;
  logic [WORD_W-1:0] wr_word;
  logic              xfer;
  logic              last_beat;
  logic              ram_we;

  for (genvar j = 0; j < P; j++) begin : g_flat
    assign beat_flat[j*PRECISION_0 +: PRECISION_0] = bus.data_in[j];
  end

  // Ready depends on registered state only, never on valid.
  assign bus.data_in_ready = (state_q == ST_LOAD);
  assign bus.done          = (state_q == ST_DONE);
  assign xfer              = bus.data_in_valid && (state_q == ST_LOAD);
  assign last_beat         = (beat_cnt_q == LAST_BEAT);
  assign ram_we            = xfer && last_beat;

  // The last beat never goes through the accumulator: it is concatenated
  // straight onto the stored beats so the word is written on that edge.
  if (BEATS_PER_WORD > 1) begin : g_acc
    localparam int ACC_W = BEAT_W * (BEATS_PER_WORD - 1);
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
      acc_d = acc_q;
      if (xfer && !last_beat) begin
        for (int b = 0; b < BEATS_PER_WORD - 1; b++) begin
          if (beat_cnt_q == BCW'(b)) begin
            acc_d[b*BEAT_W +: BEAT_W] = beat_flat;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
    end

    assign wr_word = {beat_flat, acc_q};
  end else begin : g_no_acc
    assign wr_word = beat_flat;
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              state_d    = ST_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d    = ST_LOAD;
          beat_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

`ifdef PARAM_STREAM_SINK_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] checksum_q, checksum_d, beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < P; j++) begin
      beat_sum = beat_sum + CHECKSUM_WIDTH'(bus.data_in[j]);
    end
    checksum_d = checksum_q;
    if (xfer) begin
      checksum_d = checksum_q + beat_sum;
    end else if ((state_q == ST_DONE) && bus.start) begin
      checksum_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

  param_stream_sink_ram #(
    .DWIDTH (WORD_W),
    .DEPTH  (MEM_DEPTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .we_i      (ram_we),
    .waddr_i   (word_cnt_q),
    .wdata_i   (wr_word),
    .rd_addr_i (bus.rd_addr),
    .rd_ce_i   (bus.rd_ce),
    .rd_data_o (bus.rd_data)
  );

endmodule
`default_nettype wire

// File: doc/param_stream_sink.md
Name: param_stream_sink

Overview:
Receiving end of the parameter-stream protocol that the ROM-backed weight/bias sources drive.
- Accepts valid/ready beats of PARALLELISM_DIM_0*PARALLELISM_DIM_1 fixed-point elements.
- Packs beats into full tensor-row words and writes them into an internal RAM.
- Exposes a 2-cycle-latency read port with the same timing as the parameter ROMs, so captured parameters can be replayed or compared.
- Used for on-chip parameter loading and as the loopback sink in source testbenches.

Parameters:
- PRECISION_0, 16, element bit width
- TENSOR_SIZE_DIM_0, 32, elements per RAM word (one tensor row)
- PARALLELISM_DIM_0, 4, elements per beat, dim 0
- PARALLELISM_DIM_1, 1, elements per beat, dim 1
- MEM_DEPTH, 8, RAM words per load
- P (local), PARALLELISM_DIM_0*PARALLELISM_DIM_1, elements per beat
- BEATS_PER_WORD (local), TENSOR_SIZE_DIM_0/P; must divide exactly, else elaboration $error
- AWIDTH (local), $clog2(MEM_DEPTH)+1

Ports:
- clk, in, 1, clock
- rst, in, 1, reset; synchronous, active-high
- data_in, in, PRECISION_0 x P (unpacked array), beat elements; element j is the lower index within the beat
- data_in_valid, in, 1, beat valid
- data_in_ready, out, 1, sink ready
- start, in, 1, one-cycle pulse that re-arms loading
- done, out, 1, full load captured
- rd_addr, in, AWIDTH, read word address
- rd_ce, in, 1, read enable; stalls both read pipeline stages
- rd_data, out, PRECISION_0*TENSOR_SIZE_DIM_0, read word
- checksum, out, 32, running element sum (see Optional Feature)

Behaviour:
- FSM states: LOAD, DONE. Reset enters LOAD.
- Reset values: beat_cnt=0, word_cnt=0, accumulator=0, done=0, rd_data pipeline=0, checksum=0. RAM contents are not reset.
- data_in_ready = (state==LOAD), registered-state only; no combinational path from data_in_valid.
- Handshake: a beat transfers when valid&&ready on a rising edge. valid may rise at any time; the sink never requires valid to depend on ready.
- Packing:
  - Beat b of a word (b = 0..BEATS_PER_WORD-1) fills elements [b*P .. b*P+P-1]; element k occupies bits [k*PRECISION_0 +: PRECISION_0].
  - Beats 0..BEATS_PER_WORD-2 go to the accumulator.
  - On the last beat, {data_in, accumulator} is written to RAM[word_cnt] on that same edge. No extra write cycle.
- Counters:
  - beat_cnt wraps BEATS_PER_WORD-1 -> 0.
  - word_cnt increments on each RAM write.
  - Final write (word_cnt==MEM_DEPTH-1, last beat): word_cnt wraps to 0, state -> DONE, done=1 and ready=0 from the next cycle.
- DONE state:
  - Beats are not accepted.
  - start -> LOAD and clears done, beat_cnt, word_cnt and checksum on the next edge.
  - start in LOAD is ignored.
- Read port:
  - Two registered stages, both gated by rd_ce.
  - rd_data = RAM[rd_addr] two rd_ce-enabled edges after the address is sampled.
  - rd_addr >= MEM_DEPTH returns 0.
  - Reads are legal in any state.
  - Same-address read/write on one edge returns the old data (read-first).
- Reset mid-load discards the partial word. Words already written stay in RAM but are invalid until done.
- No beats are lost or duplicated under any valid/ready pattern.

Optional Feature:
- Macro: PARAM_STREAM_SINK_CHECKSUM_EN
- Defined:
  - checksum accumulates the sum of all accepted elements, zero-extended unsigned, mod 2^32.
  - It updates on the handshake edge, is held in DONE, and is cleared by rst or start.
- Undefined: checksum is tied to 0 and no adder logic is generated.

Decomposition:
- Package param_stream_pkg holds:
  - state enum typedef (LOAD, DONE)
  - DEFAULT_PRECISION = 16
  - CHECKSUM_WIDTH = 32
  - READ_LATENCY = 2
- One sub-module: param_stream_sink_ram, a simple dual-port RAM with one write port and a 2-stage read pipeline with ce, read-first.
- FSM, packing and checksum stay in the top module.

Test Plan:
- Continuous stream, defaults: 64 beats with element value = global element index (0..255), valid held high.
  - done rises the cycle after beat 63.
  - Reading addr 3 returns elements 96..127 after 2 rd_ce cycles.
  - checksum = 32640 (with _EN).
- Random valid gaps (~40% duty): same 64 beats.
  - Identical RAM contents; no drop or duplicate.
  - ready stays 1 until done.
- Overrun: keep valid=1 after done.
  - ready=0 and RAM unchanged.
  - Then pulse start and send 64 beats of 0xFFFF: all words read 0xFFFF..., checksum = 64*4*65535 = 16776960.
- Reset after 10 beats, then a full 64-beat load of pattern index+1000.
  - Word 0 holds 1000..1031, with no residue from the first attempt.
- Read port:
  - rd_addr=9 -> rd_data=0.
  - rd_ce=0 for 3 cycles holds rd_data.
  - Reading word 1 on the same edge as the final beat of word 1 is written returns the old contents; the next read returns the new ones.
- Macro off: checksum stays 0 throughout the continuous-stream test.
